// File: rtl/fpg8_ctrl_pkg.sv
// Shared types and encodings for the FPG8 control sequencer: state set,
// ALU and register-select codes, and the opcode map.
package fpg8_ctrl_pkg;

    localparam int WAIT_CNT_W = 8;

    typedef enum logic [4:0] {
        S_IDLE,
        S_F1,
        S_F2,
        S_F3,
        S_BR,
        S_E12_1,
        S_E12_2,
        S_E13,
        S_E6,
        S_E7_1,
        S_E7_2,
        S_E8_2,
        S_A1,
        S_A2,
        S_INV,
        S_SHL,
        S_SHR,
        S_WB,
        S_INT1,
        S_INT2,
        S_INT3,
        S_INT4,
        S_HALT
    } state_e;

    localparam logic [2:0] ALU_ADD     = 3'b000;
    localparam logic [2:0] ALU_AND     = 3'b001;
    localparam logic [2:0] ALU_INC_Y   = 3'b010;
    localparam logic [2:0] ALU_INV     = 3'b011;
    localparam logic [2:0] ALU_OR      = 3'b100;
    localparam logic [2:0] ALU_PASS_Y  = 3'b101;
    localparam logic [2:0] ALU_SUB     = 3'b110;
    localparam logic [2:0] ALU_ADD_DEC = 3'b111;

    localparam logic [2:0] GPR_ZERO = 3'b000;
    localparam logic [2:0] GPR_PC   = 3'b001;
    localparam logic [2:0] GPR_RD1  = 3'b010;
    localparam logic [2:0] GPR_RD2  = 3'b011;
    localparam logic [2:0] GPR_RS1  = 3'b100;
    localparam logic [2:0] GPR_RS2  = 3'b101;
    localparam logic [2:0] GPR_LINK = 3'b110;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_INV   = 4'd4;
    localparam logic [3:0] OP_SHIFT = 4'd5;
    localparam logic [3:0] OP_MOVY  = 4'd6;
    localparam logic [3:0] OP_LOAD  = 4'd7;
    localparam logic [3:0] OP_STORE = 4'd8;
    localparam logic [3:0] OP_BRN   = 4'd9;
    localparam logic [3:0] OP_BRZ   = 4'd10;
    localparam logic [3:0] OP_BR    = 4'd11;
    localparam logic [3:0] OP_JSR   = 4'd12;
    localparam logic [3:0] OP_JRD   = 4'd13;

    // States that wait on the RAM handshake.
    function automatic logic is_mem_state(input state_e s);
        return (s == S_F1) || (s == S_E7_1) || (s == S_E8_2);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts not-ready cycles of one memory access; flags expiry on the cycle
// the count would reach TIMEOUT.
module mem_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    import fpg8_ctrl_pkg::*;

    logic [WAIT_CNT_W-1:0] count_q;
    logic [WAIT_CNT_W-1:0] count_d;

    assign expired = enable && (count_q == WAIT_CNT_W'(TIMEOUT - 1));

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expired) begin
            count_d = count_q + WAIT_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle microsequencer for the FPG8 datapath: fetch/decode/execute with
// memory wait states, bus timeout, interrupt entry and resumable halt.
module control_sequencer #(
    parameter int INSTR_WIDTH = 16,
    parameter int MEM_TIMEOUT = 15,
    parameter int IRQ_EN      = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   run,
    input  logic [1:0]             PSW_bits,
    input  logic [INSTR_WIDTH-1:0] instruction,
    input  logic                   mem_ready,
    input  logic                   irq,
    output logic [2:0]             ALU_control,
    output logic [2:0]             GPR_select,
    output logic                   GPR_in,
    output logic                   GPR_out,
    output logic                   IR_in,
    output logic                   MAR_in,
    output logic                   MDR_in,
    output logic                   MDR_out,
    output logic                   RAM_enable_read,
    output logic                   RAM_enable_write,
    output logic                   Y_in,
    output logic                   Y_out,
    output logic                   Y_offset_in,
    output logic                   Y_shift_left,
    output logic                   Y_shift_right,
    output logic                   Z_in,
    output logic                   Z_out,
    output logic                   halted,
    output logic                   irq_ack,
    output logic                   bus_error
);
    import fpg8_ctrl_pkg::*;

    state_e state_q, state_d;
    logic   bus_error_q, bus_error_d;

    logic [3:0] opcode;
    logic [2:0] rs2;
    logic       irq_take;
    state_e     end_state;
    logic       mem_state;
    logic       timer_clear;
    logic       timer_enable;
    logic       timer_expired;

    assign opcode    = instruction[INSTR_WIDTH-1 -: 4];
    assign rs2       = instruction[2:0];
    assign irq_take  = (IRQ_EN != 0) && irq;
    assign end_state = irq_take ? S_INT1 : S_F1;

    // The counter restarts whenever an access completes or we are not waiting.
    assign mem_state    = is_mem_state(state_q);
    assign timer_enable = mem_state && !mem_ready;
    assign timer_clear  = !mem_state || mem_ready;

    mem_wait_timer #(
        .TIMEOUT(MEM_TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .enable (timer_enable),
        .expired(timer_expired)
    );

    always_comb begin
        state_d     = state_q;
        bus_error_d = bus_error_q | timer_expired;
        case (state_q)
            S_IDLE:  state_d = S_F1;
            S_F1: begin
                if (mem_ready)          state_d = S_F2;
                else if (timer_expired) state_d = S_HALT;
            end
            S_F2:    state_d = S_F3;
            S_F3: begin
                case (opcode)
                    OP_BR:                        state_d = S_BR;
                    OP_BRN:                       state_d = PSW_bits[1] ? S_BR : end_state;
                    OP_BRZ:                       state_d = PSW_bits[0] ? S_BR : end_state;
                    OP_JSR:                       state_d = S_E12_1;
                    OP_JRD:                       state_d = S_E13;
                    OP_MOVY:                      state_d = S_E6;
                    OP_LOAD, OP_STORE:            state_d = S_E7_1;
                    OP_ADD, OP_SUB, OP_AND, OP_OR: state_d = (instruction == '0) ? S_HALT : S_A1;
                    OP_INV:                       state_d = S_INV;
                    OP_SHIFT:                     state_d = (rs2 == 3'd0) ? S_SHL : S_SHR;
                    default:                      state_d = end_state;
                endcase
            end
            S_E12_1: state_d = S_E12_2;
            S_E12_2: state_d = S_BR;
            S_E13:   state_d = S_BR;
            S_E7_1: begin
                if (mem_ready)          state_d = (opcode == OP_STORE) ? S_E8_2 : S_E7_2;
                else if (timer_expired) state_d = S_HALT;
            end
            S_E8_2: begin
                if (mem_ready)          state_d = end_state;
                else if (timer_expired) state_d = S_HALT;
            end
            S_A1:    state_d = S_A2;
            S_A2, S_INV, S_SHL, S_SHR:       state_d = S_WB;
            S_BR, S_E6, S_E7_2, S_WB:        state_d = end_state;
            S_INT1:  state_d = S_INT2;
            S_INT2:  state_d = S_INT3;
            S_INT3:  state_d = S_INT4;
            S_INT4:  state_d = S_F1;
            // A bus error pins the core in HALT until reset.
            S_HALT: begin
                if (run && !bus_error_q) state_d = S_F1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_error_q <= bus_error_d;
        end
    end

    always_comb begin
        ALU_control      = ALU_ADD;
        GPR_select       = GPR_ZERO;
        GPR_in           = 1'b0;
        GPR_out          = 1'b0;
        IR_in            = 1'b0;
        MAR_in           = 1'b0;
        MDR_in           = 1'b0;
        MDR_out          = 1'b0;
        RAM_enable_read  = 1'b0;
        RAM_enable_write = 1'b0;
        Y_in             = 1'b0;
        Y_out            = 1'b0;
        Y_offset_in      = 1'b0;
        Y_shift_left     = 1'b0;
        Y_shift_right    = 1'b0;
        Z_in             = 1'b0;
        Z_out            = 1'b0;
        halted           = 1'b0;
        irq_ack          = 1'b0;
        case (state_q)
            S_F1: begin
                GPR_out = 1'b1; GPR_select = GPR_PC; ALU_control = ALU_INC_Y;
                MAR_in = 1'b1; RAM_enable_read = 1'b1; Y_in = 1'b1; Z_in = 1'b1;
            end
            S_F2: begin
                IR_in = 1'b1; MDR_out = 1'b1; Y_offset_in = 1'b1;
            end
            S_F3: begin
                ALU_control = ALU_ADD_DEC; GPR_in = 1'b1; GPR_select = GPR_PC;
                Z_in = 1'b1; Z_out = 1'b1;
            end
            S_BR:    begin GPR_in = 1'b1; GPR_select = GPR_PC; Z_out = 1'b1; end
            S_E12_1: begin GPR_out = 1'b1; GPR_select = GPR_PC; Y_in = 1'b1; end
            S_E12_2: begin GPR_in = 1'b1; GPR_select = GPR_RD2; Y_out = 1'b1; end
            S_E13: begin
                ALU_control = ALU_ADD; GPR_out = 1'b1; GPR_select = GPR_RD2; Z_in = 1'b1;
            end
            S_E6:    begin GPR_in = 1'b1; GPR_select = GPR_RD2; Y_out = 1'b1; end
            S_E7_1:  begin MAR_in = 1'b1; RAM_enable_read = 1'b1; Z_out = 1'b1; end
            S_E7_2:  begin MDR_out = 1'b1; GPR_in = 1'b1; GPR_select = GPR_RD2; end
            S_E8_2: begin
                GPR_out = 1'b1; GPR_select = GPR_RD2; MDR_in = 1'b1; RAM_enable_write = 1'b1;
            end
            S_A1:    begin GPR_out = 1'b1; GPR_select = GPR_RS2; Y_in = 1'b1; end
            S_A2: begin
                case (opcode)
                    OP_SUB:  ALU_control = ALU_SUB;
                    OP_AND:  ALU_control = ALU_AND;
                    OP_OR:   ALU_control = ALU_OR;
                    default: ALU_control = ALU_ADD;
                endcase
                GPR_out = 1'b1; GPR_select = GPR_RS1; Y_shift_left = 1'b1; Z_in = 1'b1;
            end
            S_INV: begin
                ALU_control = ALU_INV; GPR_out = 1'b1; GPR_select = GPR_RS1; Z_in = 1'b1;
            end
            S_SHL, S_SHR: begin
                ALU_control = ALU_PASS_Y; GPR_out = 1'b1; GPR_select = GPR_RS1;
                Y_in = 1'b1; Z_in = 1'b1;
                Y_shift_left  = (state_q == S_SHL);
                Y_shift_right = (state_q == S_SHR);
            end
            S_WB:    begin GPR_in = 1'b1; GPR_select = GPR_RD1; Z_out = 1'b1; end
            S_INT1:  begin GPR_out = 1'b1; GPR_select = GPR_PC; Y_in = 1'b1; irq_ack = 1'b1; end
            S_INT2:  begin Y_out = 1'b1; GPR_in = 1'b1; GPR_select = GPR_LINK; end
            S_INT3:  begin GPR_out = 1'b1; GPR_select = GPR_ZERO; Y_in = 1'b1; end
            S_INT4:  begin Y_out = 1'b1; GPR_in = 1'b1; GPR_select = GPR_PC; end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

    assign bus_error = bus_error_q;

endmodule
